// File: rtl/irda_sir_tx_ctrl.sv
// Frame sequencer for the SIR pulse encoder: takes bytes over valid/ready and
// drives stx_pad_o/tx_select as a UART frame, one bit per 16 fast_enable ticks.
module irda_sir_tx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned GAP_BITS  = 0
) (
  input  logic                 clk,
  input  logic                 wb_rst_n,
  input  logic                 fast_enable,
  input  logic                 fast_mode,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 stx_pad_o,
  output logic                 tx_select,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [3:0] DB_L = 4'(DATA_BITS);
  localparam logic [3:0] SB_L = 4'(STOP_BITS);
  localparam logic [3:0] GB_L = 4'(GAP_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt16, cnt16_nxt;
  logic [3:0]           bitcnt, bitcnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_bit, par_nxt;
  logic                 stx_nxt, tsel_nxt, fdone_nxt;
  logic                 par_calc;

  assign par_calc = (PARITY == 1) ? ~^tx_data : ^tx_data;
  assign tx_ready = (state == IDLE) && !fast_mode;
  assign busy     = (state != IDLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      cnt16      <= '0;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stx_pad_o  <= 1'b1;
      tx_select  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt16      <= cnt16_nxt;
      bitcnt     <= bitcnt_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_nxt;
      stx_pad_o  <= stx_nxt;
      tx_select  <= tsel_nxt;
      frame_done <= fdone_nxt;
    end
  end

  // Next-state logic: next bit is registered on the last tick of each period so
  // it is already stable when the encoder's counter wraps to 0.
  always_comb begin
    state_nxt  = state;
    cnt16_nxt  = cnt16;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    par_nxt    = par_bit;
    stx_nxt    = stx_pad_o;
    tsel_nxt   = tx_select;
    fdone_nxt  = 1'b0;
    if (fast_mode) begin
      state_nxt = IDLE;
      cnt16_nxt = '0;
      stx_nxt   = 1'b1;
      tsel_nxt  = 1'b0;
    end else if (state == IDLE) begin
      if (tx_valid) begin
        state_nxt  = START;
        shreg_nxt  = tx_data;
        par_nxt    = par_calc;
        stx_nxt    = 1'b0;
        tsel_nxt   = 1'b1;
        cnt16_nxt  = '0;
        bitcnt_nxt = '0;
      end
    end else if (fast_enable) begin
      cnt16_nxt = cnt16 + 4'd1;
      if (cnt16 == 4'd15) begin
        case (state)
          START: begin
            state_nxt  = DATA;
            stx_nxt    = shreg[0];
            shreg_nxt  = shreg >> 1;
            bitcnt_nxt = 4'd1;
          end
          DATA: begin
            if (bitcnt == DB_L) begin
              bitcnt_nxt = 4'd1;
              if (PARITY != 0) begin
                state_nxt = PAR;
                stx_nxt   = par_bit;
              end else begin
                state_nxt = STOP;
                stx_nxt   = 1'b1;
              end
            end else begin
              stx_nxt    = shreg[0];
              shreg_nxt  = shreg >> 1;
              bitcnt_nxt = bitcnt + 4'd1;
            end
          end
          PAR: begin
            state_nxt  = STOP;
            stx_nxt    = 1'b1;
            bitcnt_nxt = 4'd1;
          end
          STOP: begin
            if (bitcnt == SB_L) begin
              bitcnt_nxt = 4'd1;
              if (GAP_BITS != 0) begin
                state_nxt = GAP;
              end else begin
                state_nxt = IDLE;
                tsel_nxt  = 1'b0;
                fdone_nxt = 1'b1;
              end
            end else begin
              bitcnt_nxt = bitcnt + 4'd1;
            end
          end
          GAP: begin
            if (bitcnt == GB_L) begin
              state_nxt = IDLE;
              tsel_nxt  = 1'b0;
              fdone_nxt = 1'b1;
            end else begin
              bitcnt_nxt = bitcnt + 4'd1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irda_sir_tx_ctrl.sv
// Bench for irda_sir_tx_ctrl: four differently configured instances, frames
// checked bit-period by bit-period against a frame-list reference model.
module tb_irda_sir_tx_ctrl;

  logic       clk;
  logic       wb_rst_n;
  logic       fe;
  logic       fast_mode;
  logic [7:0] txd [4];
  logic [3:0] tx_valid;
  logic [3:0] rdy, stx, tsel, bsy, fdone;

  int cfg_db   [4] = '{8, 8, 8, 7};
  int cfg_par  [4] = '{0, 2, 1, 1};
  int cfg_stop [4] = '{1, 1, 1, 2};
  int cfg_gap  [4] = '{0, 0, 0, 2};

  int checks = 0;
  int errors = 0;
  int fe_mode = 0;

  irda_sir_tx_ctrl #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0)) u0 (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fe), .fast_mode(fast_mode),
    .tx_data(txd[0]), .tx_valid(tx_valid[0]), .tx_ready(rdy[0]), .stx_pad_o(stx[0]),
    .tx_select(tsel[0]), .busy(bsy[0]), .frame_done(fdone[0]));
  irda_sir_tx_ctrl #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_BITS(0)) u1 (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fe), .fast_mode(fast_mode),
    .tx_data(txd[1]), .tx_valid(tx_valid[1]), .tx_ready(rdy[1]), .stx_pad_o(stx[1]),
    .tx_select(tsel[1]), .busy(bsy[1]), .frame_done(fdone[1]));
  irda_sir_tx_ctrl #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .GAP_BITS(0)) u2 (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fe), .fast_mode(fast_mode),
    .tx_data(txd[2]), .tx_valid(tx_valid[2]), .tx_ready(rdy[2]), .stx_pad_o(stx[2]),
    .tx_select(tsel[2]), .busy(bsy[2]), .frame_done(fdone[2]));
  irda_sir_tx_ctrl #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .GAP_BITS(2)) u3 (
    .clk(clk), .wb_rst_n(wb_rst_n), .fast_enable(fe), .fast_mode(fast_mode),
    .tx_data(txd[3][6:0]), .tx_valid(tx_valid[3]), .tx_ready(rdy[3]), .stx_pad_o(stx[3]),
    .tx_select(tsel[3]), .busy(bsy[3]), .frame_done(fdone[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: every 4th clk, random, or stopped
  initial begin
    int phase;
    phase = 0;
    fe = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (fe_mode)
        0: begin fe = (phase == 3); phase = (phase + 1) % 4; end
        1: fe = ($urandom_range(0, 2) == 0);
        default: fe = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sends one byte on instance d and checks the whole frame. With chain set,
  // tx_valid stays high with nxt on tx_data so the next byte is pending.
  task automatic send_frame(input int d, input logic [7:0] data, input bit chain,
                            input logic [7:0] nxt);
    int bits[$];
    int first_obs[32];
    int last_obs[32];
    int ones, n, waited, ticks, cyc, pulses, idx, pos;
    bits.delete();
    bits.push_back(0);
    ones = 0;
    for (int i = 0; i < cfg_db[d]; i++) begin
      bits.push_back(int'(data[i]));
      ones += int'(data[i]);
    end
    if (cfg_par[d] == 1) bits.push_back((ones % 2 == 0) ? 1 : 0);
    else if (cfg_par[d] == 2) bits.push_back(ones % 2);
    for (int i = 0; i < cfg_stop[d] + cfg_gap[d]; i++) bits.push_back(1);
    n = bits.size();
    for (int i = 0; i < 32; i++) begin first_obs[i] = -1; last_obs[i] = -1; end

    if (!tx_valid[d]) begin
      @(posedge clk);
      #1;
      txd[d] = data;
      tx_valid[d] = 1'b1;
      @(negedge clk);
    end
    waited = 0;
    while (!rdy[d] && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", waited, 0);
    @(posedge clk);
    #1;
    if (chain) txd[d] = nxt;
    else tx_valid[d] = 1'b0;
    @(negedge clk);
    check("busy_start", bsy[d], 1);
    check("tsel_start", tsel[d], 1);
    check("ready_start", rdy[d], 0);
    check("fdone_start", fdone[d], 0);

    ticks = 0; cyc = 0; pulses = 0;
    while (tsel[d] && cyc < 20000) begin
      if (fe) begin
        idx = ticks / 16;
        pos = ticks % 16;
        if (idx < 32) begin
          if (pos == 0)  first_obs[idx] = int'(stx[d]);
          if (pos == 15) last_obs[idx]  = int'(stx[d]);
        end
        ticks++;
      end
      if (fdone[d]) pulses++;
      @(negedge clk);
      cyc++;
    end
    check("frame_ticks", ticks, 16 * n);
    check("fdone_mid", pulses, 0);
    check("fdone_end", fdone[d], 1);
    check("stx_end", stx[d], 1);
    check("busy_end", bsy[d], 0);
    check("ready_end", rdy[d], 1);
    for (int i = 0; i < n && i < 32; i++) begin
      check($sformatf("bit%0d_first", i), first_obs[i], bits[i]);
      check($sformatf("bit%0d_last", i), last_obs[i], bits[i]);
    end
  endtask

  // Starts a frame on instance d and returns after `target` ticks were sampled
  task automatic start_and_run(input int d, input logic [7:0] data, input int target);
    int ticks, cyc;
    @(posedge clk);
    #1;
    txd[d] = data;
    tx_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[d] = 1'b0;
    ticks = 0; cyc = 0;
    @(negedge clk);
    while (ticks < target && cyc < 5000) begin
      if (fe && tsel[d]) ticks++;
      if (ticks < target) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("run_ticks", ticks, target);
  endtask

  task automatic abort_test(input int d);
    start_and_run(d, 8'h96, 70);
    @(posedge clk);
    #1;
    fast_mode = 1'b1;
    tx_valid[d] = 1'b1;
    @(negedge clk);
    check("fm_ready_comb", rdy[d], 0);
    check("fm_busy_before", bsy[d], 1);
    @(negedge clk);
    check("fm_tsel", tsel[d], 0);
    check("fm_stx", stx[d], 1);
    check("fm_busy", bsy[d], 0);
    check("fm_fdone", fdone[d], 0);
    check("fm_ready", rdy[d], 0);
    repeat (3) begin
      @(negedge clk);
      check("fm_no_accept", bsy[d], 0);
    end
    @(posedge clk);
    #1;
    fast_mode = 1'b0;
    tx_valid[d] = 1'b0;
    @(negedge clk);
    check("fm_release_ready", rdy[d], 1);
    check("fm_release_fdone", fdone[d], 0);
  endtask

  task automatic reset_test(input int d);
    start_and_run(d, 8'h5A, 40);
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("rst_tsel", tsel[d], 0);
    check("rst_stx", stx[d], 1);
    check("rst_busy", bsy[d], 0);
    check("rst_fdone", fdone[d], 0);
    @(negedge clk);
    @(negedge clk);
    wb_rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", rdy[d], 1);
    check("rst_release_busy", bsy[d], 0);
    check("rst_release_fdone", fdone[d], 0);
  endtask

  initial begin
    wb_rst_n = 1'b1;
    fast_mode = 1'b0;
    tx_valid = '0;
    for (int i = 0; i < 4; i++) txd[i] = '0;
    #2;
    wb_rst_n = 1'b0;
    #1;
    check("reset_stx", stx[0], 1);
    check("reset_tsel", tsel[0], 0);
    check("reset_busy", bsy[0], 0);
    check("reset_fdone", fdone[0], 0);
    repeat (3) @(negedge clk);
    wb_rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", rdy[0], 1);

    fe_mode = 0;
    send_frame(0, 8'hA5, 1'b0, 8'h00);
    send_frame(1, 8'h07, 1'b0, 8'h00);
    send_frame(2, 8'h07, 1'b0, 8'h00);
    send_frame(0, 8'h00, 1'b1, 8'hFF);
    send_frame(0, 8'hFF, 1'b0, 8'h00);
    send_frame(3, 8'h4B, 1'b0, 8'h00);

    fe_mode = 1;
    for (int k = 0; k < 12; k++) begin
      int d;
      logic [7:0] data;
      d = $urandom_range(0, 3);
      data = 8'($urandom);
      send_frame(d, data, 1'b0, 8'h00);
    end

    fe_mode = 0;
    abort_test(0);
    send_frame(0, 8'h3C, 1'b0, 8'h00);
    reset_test(0);
    send_frame(0, 8'hC3, 1'b0, 8'h00);
    reset_test(3);
    send_frame(3, 8'h2D, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
